// File: rtl/horizontal_counter_generator.sv
`default_nettype none
// ============================================================================
// horizontal_counter_generator
// 640x480@60 horizontal timing: pixel tick, line counter, HSYNC, active flag,
// scaled column. Optional prescaler built when HCNT_PRESCALE_EN is defined.
// Revision: 1.0
// ============================================================================
module horizontal_counter_generator #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int SCALE    = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] hor_cnt,
  output logic [6:0] scl_hor_cnt,
  output logic       HSYNC,
  output logic       display_on,
  output logic       new_line
);

  localparam logic [9:0] SYNC_LAST   = 10'(H_SYNC - 1);
  localparam logic [9:0] BACK_LAST   = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] ACTIVE_LAST = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] LINE_LAST   = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [2:0] SCALE_LAST  = 3'(SCALE - 1);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_BACK   = 2'd1,
    S_ACTIVE = 2'd2,
    S_FRONT  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       pix_en;
  logic [2:0] scale_cnt;

`ifdef HCNT_PRESCALE_EN
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
    end else if (prescaler == DIV_LAST) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  assign pix_en = (prescaler == DIV_LAST);
`else
  assign pix_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Any count at or beyond the line end is treated as the wrap point.
  always_comb begin
    state_next = state;
    if (pix_en) begin
      if (hor_cnt >= LINE_LAST) begin
        state_next = S_SYNC;
      end else begin
        case (state)
          S_SYNC:   if (hor_cnt == SYNC_LAST)   state_next = S_BACK;
          S_BACK:   if (hor_cnt == BACK_LAST)   state_next = S_ACTIVE;
          S_ACTIVE: if (hor_cnt == ACTIVE_LAST) state_next = S_FRONT;
          default:  state_next = state;
        endcase
      end
    end
  end

  // Outputs are registered from the next state so they align with hor_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      hor_cnt     <= '0;
      scale_cnt   <= '0;
      scl_hor_cnt <= '0;
      HSYNC       <= 1'b0;
      display_on  <= 1'b0;
      new_line    <= 1'b0;
      pix_tick    <= 1'b0;
    end else begin
      pix_tick   <= pix_en;
      HSYNC      <= (state_next != S_SYNC);
      display_on <= (state_next == S_ACTIVE);
      new_line   <= pix_en && (hor_cnt >= LINE_LAST);
      if (pix_en) begin
        if (hor_cnt >= LINE_LAST) begin
          hor_cnt     <= '0;
          scale_cnt   <= '0;
          scl_hor_cnt <= '0;
        end else begin
          hor_cnt <= hor_cnt + 10'd1;
          if (state == S_ACTIVE) begin
            if (scale_cnt == SCALE_LAST) begin
              scale_cnt   <= '0;
              scl_hor_cnt <= scl_hor_cnt + 7'd1;
            end else begin
              scale_cnt <= scale_cnt + 3'd1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_horizontal_counter_generator.sv
`default_nettype none
// tb_horizontal_counter_generator: random reset/run stimulus, line-position
// reference model feeding a scoreboard drained by a monitor.
module tb_horizontal_counter_generator;

`ifdef HCNT_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif
  localparam int LINE = 800;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       pix_tick;
  logic [9:0] hor_cnt;
  logic [6:0] scl_hor_cnt;
  logic       HSYNC;
  logic       display_on;
  logic       new_line;

  horizontal_counter_generator #(
    .CLK_DIV (4),
    .H_SYNC  (96),
    .H_BACK  (48),
    .H_ACTIVE(640),
    .H_FRONT (16),
    .SCALE   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick),
    .hor_cnt    (hor_cnt),
    .scl_hor_cnt(scl_hor_cnt),
    .HSYNC      (HSYNC),
    .display_on (display_on),
    .new_line   (new_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    bit tick;
    int hc;
    int scl;
    bit hs;
    bit de;
    bit nl;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   mcyc    = 0;
  int   since   = 0;
  int   cur_pos = 0;
  int   k       = 1;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, mcyc);
    end
  endtask

  // Reference: pixel position is the number of completed pixel periods since
  // reset release, modulo the line length; outputs follow from that position.
  task automatic drive(input bit r);
    exp_t e;
    reset = r;
    e = '{stamp: k, tick: 1'b0, hc: 0, scl: 0, hs: 1'b0, de: 1'b0, nl: 1'b0};
    if (r) begin
      since   = 0;
      cur_pos = 0;
      sb.push_back(e);
    end else begin
      since++;
      if (since % DIV == 0) begin
        cur_pos = (since / DIV) % LINE;
        e.tick  = 1'b1;
        e.hc    = cur_pos;
        e.hs    = (cur_pos >= 96);
        e.de    = (cur_pos >= 144) && (cur_pos <= 783);
        e.scl   = e.de ? (cur_pos - 144) / 5 : 0;
        e.nl    = (cur_pos == 0);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    k++;
  endtask

  exp_t mon_e;
  exp_t mon_last;
  int   last_nl;

  initial begin
    mon_last = '{stamp: 0, tick: 1'b0, hc: 0, scl: 0, hs: 1'b0, de: 1'b0, nl: 1'b0};
    last_nl  = -1;
    forever begin
      @(negedge clk);
      mcyc++;
      if (sb.size() > 0 && sb[0].stamp == mcyc) begin
        mon_e = sb.pop_front();
        chk(mon_e.tick ? "pix_tick" : "reset_pix_tick", int'(pix_tick), int'(mon_e.tick));
        chk("hor_cnt",     int'(hor_cnt),     mon_e.hc);
        chk("scl_hor_cnt", int'(scl_hor_cnt), mon_e.scl);
        chk("HSYNC",       int'(HSYNC),       int'(mon_e.hs));
        chk("display_on",  int'(display_on),  int'(mon_e.de));
        chk("new_line",    int'(new_line),    int'(mon_e.nl));
        mon_last = mon_e;
        if (!mon_e.tick) last_nl = mcyc;
      end else begin
        chk("idle_pix_tick",   int'(pix_tick),    0);
        chk("idle_new_line",   int'(new_line),    0);
        chk("hold_hor_cnt",    int'(hor_cnt),     mon_last.hc);
        chk("hold_scl",        int'(scl_hor_cnt), mon_last.scl);
        chk("hold_HSYNC",      int'(HSYNC),       int'(mon_last.hs));
        chk("hold_display_on", int'(display_on),  int'(mon_last.de));
      end
      chk("sync_in_active", int'(!HSYNC && display_on), 0);
      if (new_line) begin
        if (last_nl >= 0) chk("new_line_period", mcyc - last_nl, LINE * DIV);
        last_nl = mcyc;
      end
    end
  end

  initial begin
    int target;
    int rlen;
    int runlen;
    repeat (3) drive(1'b1);
    repeat (2 * LINE * DIV + 40) drive(1'b0);

    for (int i = 0; i < LINE * DIV && cur_pos != 400; i++) drive(1'b0);
    drive(1'b1);
    repeat (LINE * DIV + LINE * DIV / 2) drive(1'b0);

    for (int r = 0; r < 4; r++) begin
      target = int'($urandom_range(1, 799));
      for (int i = 0; i < LINE * DIV && cur_pos != target; i++) drive(1'b0);
      rlen = int'($urandom_range(1, 3));
      repeat (rlen) drive(1'b1);
      runlen = int'($urandom_range(LINE + 10, 2 * LINE)) * DIV;
      repeat (runlen) drive(1'b0);
    end

    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
